fp_operand_stage: RTL and testbench
===================================

// Module: fp_operand_stage
// PURPOSE
// - Two-operand floating-point input stage with a valid/ready handshake and a 2-entry skid buffer.
// - Splits each operand into sign, exponent, high/low mantissa slices and hidden bit, and classifies it.
// - Optional flush-to-zero for subnormals. Feeds the reduced-precision multiplier/adder datapath.
// - Format, slice widths and buffering are parametrised; throughput is 1 pair per cycle.
// PARAMETERS
// - EXP_W  8   exponent width
// - MAN_W  23  stored mantissa width; operand width W = 1+EXP_W+MAN_W
// - MH_W   7   high mantissa slice width (MSBs of mantissa)
// - ML_W   6   low mantissa slice width (next bits below MH_W); MH_W+ML_W <= MAN_W, checked at elaboration
// PORTS
// - clk        in   1      clock
// - reset      in   1      asynchronous, active-low reset
// - in_valid   in   1      operand pair valid
// - in_ready   out  1      stage can accept a pair
// - in_a       in   W      operand A, IEEE-style {sign,exp,man}
// - in_b       in   W      operand B
// - ftz        in   1      flush subnormals to zero; sampled with the pair at accept
// - out_valid  out  1      decoded pair valid
// - out_ready  in   1      downstream accepts the pair
// - a_sign / b_sign        out  1      sign
// - a_exp / b_exp          out  EXP_W  biased exponent
// - a_hid / b_hid          out  1      hidden bit, = (exp != 0) after FTZ
// - a_man_hi / b_man_hi    out  MH_W   man[MAN_W-1 -: MH_W]
// - a_man_lo / b_man_lo    out  ML_W   man[MAN_W-MH_W-1 -: ML_W]
// - a_class / b_class      out  3      0=ZERO 1=SUB 2=NORM 3=INF 4=NAN
// - pair_special           out  1      either operand is INF or NAN
// BEHAVIOUR
// - Reset: all outputs 0, in_ready 0, buffer EMPTY. in_ready rises on the first clk edge after release.
// - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
// - Decode is combinational on in_a/in_b/ftz; the decoded result is what gets registered. Latency is 1 cycle, accept -> out_valid.
// - Classification:
//   - exp all-ones & man!=0 -> NAN
//   - exp all-ones & man==0 -> INF
//   - exp==0 & man==0 -> ZERO
//   - exp==0 & man!=0 -> SUB (ZERO if ftz)
//   - otherwise NORM
// - FTZ on a subnormal forces exp=0, hid=0 and both slices to 0. Sign is preserved.
// - Buffer states (main reg M, skid reg S):
//   - EMPTY: accept -> ONE (load M).
//   - ONE: accept & !deliver -> TWO (load S). Deliver & !accept -> EMPTY. Both -> ONE (reload M).
//   - TWO: deliver -> ONE (S moves to M). in_ready=0 here, so no accept is possible.
// - in_ready is registered, = !(next state == TWO). It drops the cycle after the second accept under stall.
// - Outputs are driven from M only, and held stable while out_valid & !out_ready.
// - Order is preserved. No pair is ever lost or duplicated.
// - Reset asserted mid-operation: the buffer is discarded immediately and out_valid drops asynchronously.
// STRUCTURE
// - Shared package fp_pkg holds:
//   - class localparams: FPC_ZERO, FPC_SUB, FPC_NORM, FPC_INF, FPC_NAN, FPC_W=3
//   - default format constants: EXP_W/MAN_W for fp32 and bf16.
// - Sub-module fp_field_decode (parametrised like this block), instantiated once per operand.
//   - Purely combinational: field split, FTZ, hidden bit, class.
// - Top level contains the handshake/skid FSM and the M/S registers.
// TESTING
// - in_a=0x3F800000, in_b=0x40490FDB, out_ready=1 -> next cycle:
//   - A: exp 0x7F, hi 0x00, lo 0x00, hid 1, NORM.
//   - B: exp 0x80, hi 0x49, lo 0x03, NORM.
//   - pair_special 0.
// - in_a=0x00400000 with ftz=0 -> a_class SUB, a_hid 0, a_man_hi 0x40. With ftz=1 -> ZERO, a_man_hi 0, a_exp 0.
// - in_a=0x7FC00000, in_b=0xFF800000 -> a_class NAN, b_class INF, b_sign 1, pair_special 1.
// - out_ready=0, offer pairs P1,P2,P3 back-to-back:
//   - P1 and P2 are accepted; in_ready goes 0 the following cycle; P3 is held.
//   - Raise out_ready: P1, P2, P3 appear on consecutive cycles, in order, without loss.
// - Continuous in_valid=1, out_ready=1 for 16 pairs -> 16 outputs on 16 consecutive cycles, in_ready stays 1.
// - Assert reset while in state TWO -> out_valid=0 and in_ready=0 at once. After release, the first new pair emerges with 1-cycle latency.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_pkg
// Brief  : Shared floating-point constants. Operand class codes and the
//          default exponent/mantissa widths of the supported storage
//          formats.
// Rev    : 1.0  initial release
// ============================================================================
package fp_pkg;

    // Operand classification codes
    localparam int          FPC_W    = 3;
    localparam logic [2:0]  FPC_ZERO = 3'd0;
    localparam logic [2:0]  FPC_SUB  = 3'd1;
    localparam logic [2:0]  FPC_NORM = 3'd2;
    localparam logic [2:0]  FPC_INF  = 3'd3;
    localparam logic [2:0]  FPC_NAN  = 3'd4;

    // Default storage formats
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_field_decode.sv
`default_nettype none
// ============================================================================
// Module : fp_field_decode
// Brief  : Purely combinational operand decoder. Splits an IEEE-style
//          {sign,exp,man} word into sign, biased exponent, hidden bit and
//          high/low mantissa slices, applies optional flush-to-zero to
//          subnormals and classifies the operand.
// Ports  : operand  in  1+EXP_W+MAN_W  raw operand
//          ftz      in  1              flush subnormals to zero
//          sign     out 1              sign bit (kept through FTZ)
//          exp      out EXP_W          biased exponent
//          hid      out 1              hidden bit, (exp != 0)
//          man_hi   out MH_W           mantissa MSB slice
//          man_lo   out ML_W           mantissa slice just below man_hi
//          cls      out FPC_W          operand class
// Rev    : 1.0  initial release
// ============================================================================
module fp_field_decode
    import fp_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int MH_W  = 7,
    parameter int ML_W  = 6
) (
    input  logic [EXP_W+MAN_W:0] operand,
    input  logic                 ftz,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic                 hid,
    output logic [MH_W-1:0]      man_hi,
    output logic [ML_W-1:0]      man_lo,
    output logic [FPC_W-1:0]     cls
);

    if (MH_W + ML_W > MAN_W) begin : g_slice_check
        $error("fp_field_decode: MH_W + ML_W exceeds MAN_W");
    end

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_man_zero;
    logic             w_flush;

    assign w_exp      = operand[MAN_W +: EXP_W];
    assign w_man      = operand[MAN_W-1:0];
    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_man_zero = ~|w_man;
    assign w_flush    = w_exp_zero & ~w_man_zero & ftz;

    assign sign = operand[EXP_W+MAN_W];
    // A subnormal already carries exp == 0, so flushing only has to clear
    // the mantissa slices; the exponent and hidden bit fall out as zero.
    assign exp  = w_exp;
    assign hid  = ~w_exp_zero;

    assign man_hi = w_flush ? '0 : w_man[MAN_W-1 -: MH_W];
    assign man_lo = w_flush ? '0 : w_man[MAN_W-MH_W-1 -: ML_W];

    always_comb begin
        cls = FPC_NORM;
        if (w_exp_ones) begin
            cls = w_man_zero ? FPC_INF : FPC_NAN;
        end else if (w_exp_zero) begin
            cls = (w_man_zero || ftz) ? FPC_ZERO : FPC_SUB;
        end
    end

endmodule : fp_field_decode
`default_nettype wire

// File: rtl/fp_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : fp_operand_stage
// Brief  : Two-operand floating-point input stage. Decodes both operands
//          combinationally and registers the decoded pair through a
//          valid/ready handshake with a 2-entry skid buffer (main reg M,
//          skid reg S). One pair per cycle, 1-cycle accept-to-valid latency.
// Ports  : clk, reset (async, active-low)
//          in_valid/in_ready, in_a, in_b, ftz     upstream pair
//          out_valid/out_ready                    downstream handshake
//          a_*/b_* sign, exp, hid, man_hi, man_lo, class   decoded fields
//          pair_special                           either operand INF/NAN
// Rev    : 1.0  initial release
// ============================================================================
module fp_operand_stage
    import fp_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int MH_W  = 7,
    parameter int ML_W  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 ftz,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 a_sign,
    output logic [EXP_W-1:0]     a_exp,
    output logic                 a_hid,
    output logic [MH_W-1:0]      a_man_hi,
    output logic [ML_W-1:0]      a_man_lo,
    output logic [FPC_W-1:0]     a_class,
    output logic                 b_sign,
    output logic [EXP_W-1:0]     b_exp,
    output logic                 b_hid,
    output logic [MH_W-1:0]      b_man_hi,
    output logic [ML_W-1:0]      b_man_lo,
    output logic [FPC_W-1:0]     b_class,
    output logic                 pair_special
);

    typedef struct packed {
        logic             a_sign;
        logic [EXP_W-1:0] a_exp;
        logic             a_hid;
        logic [MH_W-1:0]  a_man_hi;
        logic [ML_W-1:0]  a_man_lo;
        logic [FPC_W-1:0] a_class;
        logic             b_sign;
        logic [EXP_W-1:0] b_exp;
        logic             b_hid;
        logic [MH_W-1:0]  b_man_hi;
        logic [ML_W-1:0]  b_man_lo;
        logic [FPC_W-1:0] b_class;
        logic             pair_special;
    } dec_pair_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming pair
    // ------------------------------------------------------------------
    logic             w_a_sign, w_b_sign;
    logic [EXP_W-1:0] w_a_exp,  w_b_exp;
    logic             w_a_hid,  w_b_hid;
    logic [MH_W-1:0]  w_a_hi,   w_b_hi;
    logic [ML_W-1:0]  w_a_lo,   w_b_lo;
    logic [FPC_W-1:0] w_a_cls,  w_b_cls;
    dec_pair_t        w_dec;

    fp_field_decode #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .MH_W  (MH_W),
        .ML_W  (ML_W)
    ) u_decode_a (
        .operand (in_a),
        .ftz     (ftz),
        .sign    (w_a_sign),
        .exp     (w_a_exp),
        .hid     (w_a_hid),
        .man_hi  (w_a_hi),
        .man_lo  (w_a_lo),
        .cls     (w_a_cls)
    );

    fp_field_decode #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .MH_W  (MH_W),
        .ML_W  (ML_W)
    ) u_decode_b (
        .operand (in_b),
        .ftz     (ftz),
        .sign    (w_b_sign),
        .exp     (w_b_exp),
        .hid     (w_b_hid),
        .man_hi  (w_b_hi),
        .man_lo  (w_b_lo),
        .cls     (w_b_cls)
    );

    always_comb begin
        w_dec.a_sign       = w_a_sign;
        w_dec.a_exp        = w_a_exp;
        w_dec.a_hid        = w_a_hid;
        w_dec.a_man_hi     = w_a_hi;
        w_dec.a_man_lo     = w_a_lo;
        w_dec.a_class      = w_a_cls;
        w_dec.b_sign       = w_b_sign;
        w_dec.b_exp        = w_b_exp;
        w_dec.b_hid        = w_b_hid;
        w_dec.b_man_hi     = w_b_hi;
        w_dec.b_man_lo     = w_b_lo;
        w_dec.b_class      = w_b_cls;
        w_dec.pair_special = (w_a_cls == FPC_INF) || (w_a_cls == FPC_NAN) ||
                             (w_b_cls == FPC_INF) || (w_b_cls == FPC_NAN);
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    state_t    r_state;
    state_t    w_next_state;
    logic      r_in_ready;
    dec_pair_t r_main;
    dec_pair_t r_skid;
    logic      w_accept;
    logic      w_deliver;
    logic      w_load_main;    // M <= incoming decoded pair
    logic      w_load_skid;    // S <= incoming decoded pair
    logic      w_skid_to_main; // M <= S

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = (r_state != ST_EMPTY) & out_ready;

    always_comb begin
        w_next_state   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_ONE;
                    w_load_main  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_deliver) begin
                    w_next_state = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_deliver && !w_accept) begin
                    w_next_state = ST_EMPTY;
                end else if (w_deliver && w_accept) begin
                    w_load_main  = 1'b1;
                end
            end
            ST_TWO: begin
                // in_ready is low in this state, so no accept can arrive.
                if (w_deliver) begin
                    w_next_state   = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered so in_ready never depends combinationally on
            // out_ready; the skid entry absorbs the one-cycle lag.
            r_in_ready <= (w_next_state != ST_TWO);
            if (w_load_main) begin
                r_main <= w_dec;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, driven from M only
    // ------------------------------------------------------------------
    assign in_ready     = r_in_ready;
    assign out_valid    = (r_state != ST_EMPTY);
    assign a_sign       = r_main.a_sign;
    assign a_exp        = r_main.a_exp;
    assign a_hid        = r_main.a_hid;
    assign a_man_hi     = r_main.a_man_hi;
    assign a_man_lo     = r_main.a_man_lo;
    assign a_class      = r_main.a_class;
    assign b_sign       = r_main.b_sign;
    assign b_exp        = r_main.b_exp;
    assign b_hid        = r_main.b_hid;
    assign b_man_hi     = r_main.b_man_hi;
    assign b_man_lo     = r_main.b_man_lo;
    assign b_class      = r_main.b_class;
    assign pair_special = r_main.pair_special;

endmodule : fp_operand_stage
`default_nettype wire

// File: tb/tb_fp_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_operand_stage
// Brief  : Self-checking bench for fp_operand_stage (fp32 defaults). A
//          queue-based reference model tracks accepted pairs; directed
//          vectors pin known decodes and handshake corner cases.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp_operand_stage;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic       hid;
        logic [6:0] hi;
        logic [5:0] lo;
        logic [2:0] cls;
    } op_t;

    typedef struct packed {
        op_t  a;
        op_t  b;
        logic special;
    } pair_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        ftz = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic        a_hid, b_hid;
    logic [6:0]  a_man_hi, b_man_hi;
    logic [5:0]  a_man_lo, b_man_lo;
    logic [2:0]  a_class, b_class;
    logic        pair_special;

    int    checks = 0;
    int    failures = 0;
    int    deliv_count = 0;
    logic  armed = 1'b0;
    pair_t exp_q[$];
    pair_t dut_pair;

    fp_operand_stage u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .ftz          (ftz),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .a_sign       (a_sign),
        .a_exp        (a_exp),
        .a_hid        (a_hid),
        .a_man_hi     (a_man_hi),
        .a_man_lo     (a_man_lo),
        .a_class      (a_class),
        .b_sign       (b_sign),
        .b_exp        (b_exp),
        .b_hid        (b_hid),
        .b_man_hi     (b_man_hi),
        .b_man_lo     (b_man_lo),
        .b_class      (b_class),
        .pair_special (pair_special)
    );

    always #5 clk = ~clk;

    assign dut_pair = {a_sign, a_exp, a_hid, a_man_hi, a_man_lo, a_class,
                       b_sign, b_exp, b_hid, b_man_hi, b_man_lo, b_class,
                       pair_special};

    // Reference decode written from the format rules with plain arithmetic.
    function automatic op_t model_op(input logic [31:0] w, input logic f);
        op_t         o;
        int unsigned e;
        int unsigned m;
        e = (w >> 23) & 32'hFF;
        m = w & 32'h7FFFFF;
        o.sign = w[31];
        o.exp  = e[7:0];
        o.hid  = (e != 0);
        if (e == 255)     o.cls = (m != 0) ? 3'd4 : 3'd3;
        else if (e == 0)  o.cls = (m == 0 || f) ? 3'd0 : 3'd1;
        else              o.cls = 3'd2;
        if (e == 0 && m != 0 && f) begin
            o.hi = '0;
            o.lo = '0;
        end else begin
            o.hi = 7'(m >> 16);
            o.lo = 6'((m >> 10) % 64);
        end
        return o;
    endfunction

    function automatic pair_t model_pair(input logic [31:0] a, input logic [31:0] b,
                                         input logic f);
        pair_t p;
        p.a = model_op(a, f);
        p.b = model_op(b, f);
        p.special = (p.a.cls >= 3) || (p.b.cls >= 3);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    // in_ready becomes meaningful from the first edge after reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // Per-cycle compare against the queue model.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_in_ready", 64'(in_ready), 64'd0);
            check("reset_outputs", 64'(dut_pair), 64'd0);
        end else begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(armed && exp_q.size() < 2));
            if (out_valid && exp_q.size() > 0)
                check("out_pair", 64'(dut_pair), 64'(exp_q[0]));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                deliv_count++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model_pair(in_a, in_b, ftz));
        end
    end

    // Offer one pair and return 1 time unit after the edge that accepts it.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic f);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        ftz = f;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=in_ready_low expected=accept_within_50");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Model pins
        check("pin_b_pi", 64'(model_op(32'h40490FDB, 1'b0)),
              64'({1'b0, 8'h80, 1'b1, 7'h49, 6'h03, 3'd2}));
        check("pin_sub_ftz", 64'(model_op(32'h00400000, 1'b1)),
              64'({1'b0, 8'h00, 1'b0, 7'h00, 6'h00, 3'd0}));

        // Reset state, then release; in_ready rises only on the next edge
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_a_class", 64'(a_class), 64'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 64'(in_ready), 64'd1);

        // 1.0 and pi
        out_ready = 1'b1;
        send(32'h3F800000, 32'h40490FDB, 1'b0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_a_exp", 64'(a_exp), 64'h7F);
        check("t1_a_hi", 64'(a_man_hi), 64'h00);
        check("t1_a_lo", 64'(a_man_lo), 64'h00);
        check("t1_a_hid", 64'(a_hid), 64'd1);
        check("t1_a_class", 64'(a_class), 64'd2);
        check("t1_b_exp", 64'(b_exp), 64'h80);
        check("t1_b_hi", 64'(b_man_hi), 64'h49);
        check("t1_b_lo", 64'(b_man_lo), 64'h03);
        check("t1_b_class", 64'(b_class), 64'd2);
        check("t1_special", 64'(pair_special), 64'd0);

        // Subnormal with and without flush-to-zero
        send(32'h00400000, 32'h3F800000, 1'b0);
        check("sub_class", 64'(a_class), 64'd1);
        check("sub_hid", 64'(a_hid), 64'd0);
        check("sub_hi", 64'(a_man_hi), 64'h40);
        send(32'h80400000, 32'h3F800000, 1'b1);
        check("ftz_class", 64'(a_class), 64'd0);
        check("ftz_hi", 64'(a_man_hi), 64'h00);
        check("ftz_exp", 64'(a_exp), 64'h00);
        check("ftz_sign", 64'(a_sign), 64'd1);

        // NaN / -Inf
        send(32'h7FC00000, 32'hFF800000, 1'b0);
        check("nan_a_class", 64'(a_class), 64'd4);
        check("inf_b_class", 64'(b_class), 64'd3);
        check("inf_b_sign", 64'(b_sign), 64'd1);
        check("special", 64'(pair_special), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Stall: P1, P2 fill the buffer, P3 waits until drain starts
        out_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0);
                send(32'h40000000, 32'h40000000, 1'b0);
                send(32'h40400000, 32'h40400000, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check("stall_ready_drop", 64'(in_ready), 64'd0);
                repeat (2) @(posedge clk);
                #1;
                check("stall_held_valid", 64'(out_valid), 64'd1);
                check("stall_held_p1", 64'(a_exp), 64'h7F);
                check("stall_ready_low", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Streaming: 16 pairs back to back
        base = deliv_count;
        for (int i = 0; i < 16; i++) begin
            send(32'h3F800000 + (i << 16), 32'hBF800000 + (i << 10), i[0]);
            check("stream_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        check("stream_count", 64'(deliv_count - base), 64'd16);

        // Reset while both entries are occupied
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0);
        send(32'h40400000, 32'h40800000, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_a_exp", 64'(a_exp), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        out_ready = 1'b1;
        send(32'h40490FDB, 32'h3F800000, 1'b0);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_a_hi", 64'(a_man_hi), 64'h49);
        check("post_rst_b_exp", 64'(b_exp), 64'h7F);

        repeat (3) @(posedge clk);
        #1;
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fp_operand_stage
`default_nettype wire
